decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Decode-stage controller for the 5-stage RV32I pipeline. Decodes the IF/ID instruction into the immediate-select code for the immediate generator and the control bundle for the ID/EX register.
- Sequences pipeline stalls (load-use) and flushes (EX-stage redirect for taken beq or jal) through a small FSM.
- Owns the registered control half of the ID/EX pipeline register.

Parameters:
- LOAD_USE_STALL, 1, total stall cycles per load-use hazard (≥1).
- FLUSH_CYCLES, 1, total cycles of bubbles into ID/EX per redirect (≥1).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_id_instr  in  32  instruction in ID.
- if_id_valid  in  1  ID holds a real instruction.
- id_ex_memRead  in  1  instruction now in EX is a load.
- id_ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken beq, or a jal; the PC mux redirects this cycle.
- immSel  out  2  combinational code to immGen: 00 I, 01 S, 10 SB, 11 J.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID valid at the next edge.
- ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_jump, ex_aluSrc  out  1 each  registered ID/EX control.
- ex_immSel  out  2  registered copy of immSel.
- illegal  out  1  combinational: a valid ID opcode is unrecognised.

Behaviour:
- Decode on opcode [6:0], combinational:
  - 0000011 lw: regWrite, memRead, aluSrc, immSel 00.
  - 0010011 addi: regWrite, aluSrc, immSel 00.
  - 0100011 sw: memWrite, aluSrc, immSel 01.
  - 1100011 beq: branch, immSel 10.
  - 1101111 jal: regWrite, jump, immSel 11.
  - 0110011 R-type: regWrite, immSel 00.
  - Any other opcode: all control bits 0, immSel 00, illegal = if_id_valid.
- rs2 is used only by R, S and SB types.
- hazard = id_ex_memRead & (id_ex_rd ≠ 0) & if_id_valid & ((id_ex_rd == instr[19:15]) | (rs2 used & id_ex_rd == instr[24:20])).
- FSM states: RUN, STALL, FLUSH. Two down-counters.
- RUN:
  - ex_redirect = 1 has priority over hazard. if_id_flush = 1, pc_write = 1, ID/EX loads a bubble. If FLUSH_CYCLES > 1: go to FLUSH with count FLUSH_CYCLES−1; else stay in RUN.
  - Else if hazard: pc_write = 0, if_id_write = 0, ID/EX loads a bubble. If LOAD_USE_STALL > 1: go to STALL with count LOAD_USE_STALL−1.
  - Else: pc_write = 1, if_id_write = 1, ID/EX loads the decoded bundle with ex_valid = if_id_valid & ~illegal.
- STALL: pc/if_id held, bubble each cycle, count decrements; RUN when the count reaches 0. If ex_redirect arrives in STALL, the redirect handling overrides and the state becomes FLUSH or RUN.
- FLUSH: pc_write = 1, if_id_flush = 1, bubble each cycle; count decrements; RUN at 0. A redirect in FLUSH reloads the count.
- Bubble: ex_valid and every ex_* control bit = 0, ex_immSel = 00.
- Latency: decode to ex_* outputs is 1 cycle; stall/flush outputs are combinational in the detection cycle.
- Reset (also mid-stall or mid-flush), at the next edge:
  - State RUN, counters 0.
  - All ex_* = 0.
  - While rst is high: pc_write = 0, if_id_write = 0, if_id_flush = 1.
- An illegal instruction never writes state; it propagates as a bubble. No trap is raised.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W]. Each increments on every cycle spent stalling or flushing, saturates at all-ones, and clears on rst.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with addi in ID → all ex_* = 0, pc_write = 0, if_id_flush = 1; first edge after release gives ex_valid = 1, ex_regWrite = 1, ex_aluSrc = 1, ex_immSel = 00.
- Load-use: EX holds lw x5 (memRead = 1, rd = 5), ID holds add x6,x5,x1 → 1 cycle with pc_write = 0, if_id_write = 0; next edge ex_valid = 0; following cycle add issues.
- No false hazard:
  - rd = 0 with rs1 = 0 → no stall.
  - lw rd = 7 with ID addi whose bits [24:20] = 7 → no stall (rs2 unused).
- Redirect priority: ex_redirect = 1 and hazard in the same cycle → if_id_flush = 1, pc_write = 1, bubble, no stall.
- Parameters: LOAD_USE_STALL = 3 gives 3 held cycles then RUN; FLUSH_CYCLES = 2 gives 2 bubble cycles; rst asserted in the second stall cycle → RUN next edge.
- Decode sweep: sw → immSel 01, beq → 10, jal → 11; opcode 1111111 with valid → illegal = 1, ex_valid = 0 next edge.

Source files
------------

// File: rtl/decode_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl_if
// Bundles the decode-stage signals exchanged between the RV32I pipeline and
// decode_hazard_ctrl. Signal names match the legacy port names one-for-one.
//
//   Pipeline -> controller : if_id_instr, if_id_valid, id_ex_memRead,
//                            id_ex_rd, ex_redirect
//   Controller -> pipeline : immSel, illegal (combinational decode)
//                            pc_write, if_id_write, if_id_flush (stall/flush)
//                            ex_* (registered ID/EX control half)
//
// Modports: master = pipeline side, slave = decode_hazard_ctrl.
// -----------------------------------------------------------------------------
interface decode_hazard_ctrl_if;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        id_ex_memRead;
   logic [4:0]  id_ex_rd;
   logic        ex_redirect;

   logic [1:0]  immSel;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        ex_valid;
   logic        ex_regWrite;
   logic        ex_memRead;
   logic        ex_memWrite;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_aluSrc;
   logic [1:0]  ex_immSel;
   logic        illegal;

   modport master (
      output if_id_instr, if_id_valid, id_ex_memRead, id_ex_rd, ex_redirect,
      input  immSel, pc_write, if_id_write, if_id_flush,
             ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
             ex_branch, ex_jump, ex_aluSrc, ex_immSel, illegal
   );

   modport slave (
      input  if_id_instr, if_id_valid, id_ex_memRead, id_ex_rd, ex_redirect,
      output immSel, pc_write, if_id_write, if_id_flush,
             ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
             ex_branch, ex_jump, ex_aluSrc, ex_immSel, illegal
   );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
// Decode-stage controller for the 5-stage RV32I pipeline. Decodes the IF/ID
// instruction into an immediate-select code and the ID/EX control bundle,
// detects load-use hazards, sequences stalls and EX-redirect flushes through a
// RUN/STALL/FLUSH FSM, and owns the registered control half of ID/EX.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - decode_hazard_ctrl_if.slave (instruction/hazard inputs, decode,
//          stall/flush controls, registered ex_* bundle)
//
// Parameters:
//   LOAD_USE_STALL - total stall cycles per load-use hazard (>= 1)
//   FLUSH_CYCLES   - total bubble cycles into ID/EX per redirect (>= 1)
//   CNT_W          - perf counter width (only with HAZARD_PERF_CNT_EN)
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt outputs counting cycles spent stalling / flushing.
// -----------------------------------------------------------------------------
module decode_hazard_ctrl #(
   parameter int LOAD_USE_STALL = 1,
   parameter int FLUSH_CYCLES   = 1
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W          = 32
`endif
) (
   input  logic                clk,
   input  logic                rst,
   decode_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
`endif
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_R    = 7'b0110011;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // Counters hold the cycles remaining after the entry cycle, max N-1.
   localparam int SCW = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [SCW-1:0] STALL_RELOAD = SCW'(LOAD_USE_STALL - 1);
   localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);

   // ---------------------------------------------------------------- decode
   logic [6:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unused_instr_bits;

   assign opcode            = bus.if_id_instr[6:0];
   assign rs1               = bus.if_id_instr[19:15];
   assign rs2               = bus.if_id_instr[24:20];
   assign unused_instr_bits = ^{bus.if_id_instr[31:25], bus.if_id_instr[14:7]};

   logic       dec_regwrite;
   logic       dec_memread;
   logic       dec_memwrite;
   logic       dec_branch;
   logic       dec_jump;
   logic       dec_alusrc;
   logic       dec_known;
   logic       rs2_used;
   logic [1:0] imm_sel;

   always_comb begin
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      dec_branch   = 1'b0;
      dec_jump     = 1'b0;
      dec_alusrc   = 1'b0;
      dec_known    = 1'b0;
      rs2_used     = 1'b0;
      imm_sel      = 2'b00;
      case (opcode)
         OP_LW: begin
            dec_regwrite = 1'b1;
            dec_memread  = 1'b1;
            dec_alusrc   = 1'b1;
            dec_known    = 1'b1;
         end
         OP_ADDI: begin
            dec_regwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_known    = 1'b1;
         end
         OP_SW: begin
            dec_memwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_known    = 1'b1;
            rs2_used     = 1'b1;
            imm_sel      = 2'b01;
         end
         OP_BEQ: begin
            dec_branch   = 1'b1;
            dec_known    = 1'b1;
            rs2_used     = 1'b1;
            imm_sel      = 2'b10;
         end
         OP_JAL: begin
            dec_regwrite = 1'b1;
            dec_jump     = 1'b1;
            dec_known    = 1'b1;
            imm_sel      = 2'b11;
         end
         OP_R: begin
            dec_regwrite = 1'b1;
            dec_known    = 1'b1;
            rs2_used     = 1'b1;
         end
         default: ;
      endcase
   end

   logic illegal;
   logic hazard;

   assign illegal = bus.if_id_valid & ~dec_known;
   assign hazard  = bus.id_ex_memRead & (bus.id_ex_rd != 5'd0) & bus.if_id_valid &
                    ((bus.id_ex_rd == rs1) | (rs2_used & (bus.id_ex_rd == rs2)));

   // ------------------------------------------------------------------- FSM
   logic [1:0]     state_q,      state_d;
   logic [SCW-1:0] stall_left_q, stall_left_d;
   logic [FCW-1:0] flush_left_q, flush_left_d;
   logic           pc_write;
   logic           if_id_write;
   logic           if_id_flush;
   logic           load_bubble;

   // A redirect wins in every state, so it is resolved ahead of the per-state
   // case rather than repeated in each arm.
   always_comb begin
      state_d      = state_q;
      stall_left_d = stall_left_q;
      flush_left_d = flush_left_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      load_bubble  = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         load_bubble  = 1'b1;
         state_d      = ST_RUN;
         stall_left_d = '0;
         flush_left_d = '0;
      end else if (bus.ex_redirect) begin
         if_id_flush  = 1'b1;
         load_bubble  = 1'b1;
         stall_left_d = '0;
         if (FLUSH_CYCLES > 1) begin
            state_d      = ST_FLUSH;
            flush_left_d = FLUSH_RELOAD;
         end else begin
            state_d      = ST_RUN;
            flush_left_d = '0;
         end
      end else begin
         case (state_q)
            ST_STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               load_bubble = 1'b1;
               if (stall_left_q <= SCW'(1)) begin
                  state_d      = ST_RUN;
                  stall_left_d = '0;
               end else begin
                  stall_left_d = stall_left_q - SCW'(1);
               end
            end
            ST_FLUSH: begin
               if_id_flush = 1'b1;
               load_bubble = 1'b1;
               if (flush_left_q <= FCW'(1)) begin
                  state_d      = ST_RUN;
                  flush_left_d = '0;
               end else begin
                  flush_left_d = flush_left_q - FCW'(1);
               end
            end
            default: begin
               if (hazard) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  load_bubble = 1'b1;
                  if (LOAD_USE_STALL > 1) begin
                     state_d      = ST_STALL;
                     stall_left_d = STALL_RELOAD;
                  end
               end
            end
         endcase
      end
   end

   // -------------------------------------------------- ID/EX control half
   // {valid, regWrite, memRead, memWrite, branch, jump, aluSrc, immSel[1:0]}
   logic [8:0] ex_ctl_q, ex_ctl_d;

   always_comb begin
      ex_ctl_d = '0;
      if (!load_bubble) begin
         ex_ctl_d = {bus.if_id_valid & ~illegal, dec_regwrite, dec_memread,
                     dec_memwrite, dec_branch, dec_jump, dec_alusrc, imm_sel};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         stall_left_q <= '0;
         flush_left_q <= '0;
         ex_ctl_q     <= '0;
      end else begin
         state_q      <= state_d;
         stall_left_q <= stall_left_d;
         flush_left_q <= flush_left_d;
         ex_ctl_q     <= ex_ctl_d;
      end
   end

   assign bus.immSel      = imm_sel;
   assign bus.illegal     = illegal;
   assign bus.pc_write    = pc_write;
   assign bus.if_id_write = if_id_write;
   assign bus.if_id_flush = if_id_flush;
   assign bus.ex_valid    = ex_ctl_q[8];
   assign bus.ex_regWrite = ex_ctl_q[7];
   assign bus.ex_memRead  = ex_ctl_q[6];
   assign bus.ex_memWrite = ex_ctl_q[5];
   assign bus.ex_branch   = ex_ctl_q[4];
   assign bus.ex_jump     = ex_ctl_q[3];
   assign bus.ex_aluSrc   = ex_ctl_q[2];
   assign bus.ex_immSel   = ex_ctl_q[1:0];

`ifdef HAZARD_PERF_CNT_EN
   // Stall cycles are the only non-reset cycles with both pc_write and
   // if_id_flush low; flush cycles are non-reset cycles with if_id_flush high.
   logic             stalling;
   logic             flushing;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   assign stalling = ~rst & ~pc_write & ~if_id_flush;
   assign flushing = ~rst & if_id_flush;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stalling && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flushing && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_ctrl
// Drives two decode_hazard_ctrl instances from the same stimulus:
//   dut_a : LOAD_USE_STALL = 1, FLUSH_CYCLES = 1
//   dut_b : LOAD_USE_STALL = 3, FLUSH_CYCLES = 2
// Directed scenarios use constant expectations; the random scenario uses a
// cycle-level reference model tracking remaining stall/flush cycles.
// -----------------------------------------------------------------------------
module tb_decode_hazard_ctrl;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] ROP  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        valid;
   logic        memrd;
   logic [4:0]  rd;
   logic        redir;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_hazard_ctrl_if ifa ();
   decode_hazard_ctrl_if ifb ();

   assign ifa.if_id_instr   = instr;
   assign ifa.if_id_valid   = valid;
   assign ifa.id_ex_memRead = memrd;
   assign ifa.id_ex_rd      = rd;
   assign ifa.ex_redirect   = redir;
   assign ifb.if_id_instr   = instr;
   assign ifb.if_id_valid   = valid;
   assign ifb.id_ex_memRead = memrd;
   assign ifb.id_ex_rd      = rd;
   assign ifb.ex_redirect   = redir;

   decode_hazard_ctrl #(.LOAD_USE_STALL(1), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   decode_hazard_ctrl #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   // ctl = {pc_write, if_id_write, if_id_flush}
   // ex  = {valid, regWrite, memRead, memWrite, branch, jump, aluSrc, immSel}
   logic [2:0] ctl_a, ctl_b;
   logic [8:0] exa, exb;
   assign ctl_a = {ifa.pc_write, ifa.if_id_write, ifa.if_id_flush};
   assign ctl_b = {ifb.pc_write, ifb.if_id_write, ifb.if_id_flush};
   assign exa = {ifa.ex_valid, ifa.ex_regWrite, ifa.ex_memRead, ifa.ex_memWrite,
                 ifa.ex_branch, ifa.ex_jump, ifa.ex_aluSrc, ifa.ex_immSel};
   assign exb = {ifb.ex_valid, ifb.ex_regWrite, ifb.ex_memRead, ifb.ex_memWrite,
                 ifb.ex_branch, ifb.ex_jump, ifb.ex_aluSrc, ifb.ex_immSel};

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd_f,
                                      input logic [4:0] rs1_f, input logic [4:0] rs2_f);
      return {7'd0, rs2_f, rs1_f, 3'd0, rd_f, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // ------------------------------------------------------ reference model
   int         m_stall [2];
   int         m_flush [2];
   int         n_stall [2];
   int         n_flush [2];
   logic [8:0] m_ex    [2];

   // c = {regWrite, memRead, memWrite, branch, jump, aluSrc, immSel}
   function automatic void ref_decode(input logic [6:0] op, output logic known,
                                      output logic rs2u, output logic [7:0] c);
      known = 1'b1;
      rs2u  = 1'b0;
      c     = 8'b0;
      case (op)
         LW:   c = 8'b11000100;
         ADDI: c = 8'b10000100;
         SW:   begin c = 8'b00100101; rs2u = 1'b1; end
         BEQ:  begin c = 8'b00010010; rs2u = 1'b1; end
         JAL:  c = 8'b10001011;
         ROP:  begin c = 8'b10000000; rs2u = 1'b1; end
         default: known = 1'b0;
      endcase
   endfunction

   task automatic model_eval(input int k, output logic [2:0] ctl, output logic ifw_care,
                             output logic [8:0] nxt);
      int         lus;
      int         fcy;
      logic       known;
      logic       rs2u;
      logic [7:0] c;
      logic       haz;
      lus = (k == 0) ? 1 : 3;
      fcy = (k == 0) ? 1 : 2;
      ref_decode(instr[6:0], known, rs2u, c);
      haz = memrd && (rd != 5'd0) && valid &&
            ((rd == instr[19:15]) || (rs2u && (rd == instr[24:20])));
      ifw_care   = 1'b1;
      n_stall[k] = m_stall[k];
      n_flush[k] = m_flush[k];
      if (rst) begin
         ctl = 3'b001; nxt = '0; n_stall[k] = 0; n_flush[k] = 0;
      end else if (redir || (m_flush[k] > 0)) begin
         ctl = 3'b101; ifw_care = 1'b0; nxt = '0; n_stall[k] = 0;
         n_flush[k] = redir ? fcy - 1 : m_flush[k] - 1;
      end else if ((m_stall[k] > 0) || haz) begin
         ctl = 3'b000; nxt = '0;
         n_stall[k] = (m_stall[k] > 0) ? m_stall[k] - 1 : lus - 1;
      end else begin
         ctl = 3'b110;
         nxt = {valid & known, c};
      end
   endtask

   // ------------------------------------------------------------- scenarios
   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; instr = mk(ADDI, 5'd3, 5'd2, 5'd0);
      memrd = 1'b0; rd = 5'd0; redir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (ctl_a !== 3'b001) begin n_bad++; $display("FAIL reset_ctl_a got=%b exp=001", ctl_a); end
         n_cmp++;
         if (ctl_b !== 3'b001) begin n_bad++; $display("FAIL reset_ctl_b got=%b exp=001", ctl_b); end
         tick();
         n_cmp++;
         if (exa !== 9'b0 || exb !== 9'b0) begin
            n_bad++; $display("FAIL reset_ex got_a=%b got_b=%b exp=0", exa, exb);
         end
      end
      rst = 1'b0;
      #2;
      n_cmp++;
      if (ctl_a !== 3'b110) begin n_bad++; $display("FAIL post_reset_ctl got=%b exp=110", ctl_a); end
      tick();
      n_cmp++;
      if (exa !== 9'b110000100 || exb !== 9'b110000100) begin
         n_bad++; $display("FAIL post_reset_ex got_a=%b got_b=%b exp=110000100", exa, exb);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      memrd = 1'b1; rd = 5'd5; valid = 1'b1; redir = 1'b0;
      instr = mk(ROP, 5'd6, 5'd5, 5'd1);
      #2;
      n_cmp++;
      if (ctl_a !== 3'b000) begin n_bad++; $display("FAIL lu_stall got=%b exp=000", ctl_a); end
      tick();
      n_cmp++;
      if (exa !== 9'b0) begin n_bad++; $display("FAIL lu_bubble got=%b exp=0", exa); end
      memrd = 1'b0; rd = 5'd0;
      #2;
      n_cmp++;
      if (ctl_a !== 3'b110) begin n_bad++; $display("FAIL lu_resume got=%b exp=110", ctl_a); end
      tick();
      n_cmp++;
      if (exa !== 9'b110000000) begin n_bad++; $display("FAIL lu_issue got=%b exp=110000000", exa); end
   endtask

   task automatic test_no_false_hazard();
      do_reset();
      redir = 1'b0; valid = 1'b1; memrd = 1'b1;
      rd = 5'd0; instr = mk(ADDI, 5'd4, 5'd0, 5'd0);
      #2;
      n_cmp++;
      if (ctl_a !== 3'b110) begin n_bad++; $display("FAIL nfh_rd0 got=%b exp=110", ctl_a); end
      tick();
      rd = 5'd7; instr = mk(ADDI, 5'd4, 5'd3, 5'd7);
      #2;
      n_cmp++;
      if (ctl_a !== 3'b110 || ctl_b !== 3'b110) begin
         n_bad++; $display("FAIL nfh_rs2_unused got_a=%b got_b=%b exp=110", ctl_a, ctl_b);
      end
      tick();
      instr = mk(SW, 5'd0, 5'd3, 5'd7);
      #2;
      n_cmp++;
      if (ctl_a !== 3'b000) begin n_bad++; $display("FAIL nfh_sw_rs2 got=%b exp=000", ctl_a); end
      tick();
      memrd = 1'b0;
   endtask

   task automatic test_redirect_priority();
      do_reset();
      memrd = 1'b1; rd = 5'd5; valid = 1'b1; redir = 1'b1;
      instr = mk(ROP, 5'd6, 5'd5, 5'd1);
      #2;
      n_cmp++;
      if ({ctl_a[2], ctl_a[0]} !== 2'b11) begin
         n_bad++; $display("FAIL redir_prio pc/flush got=%b exp=11", {ctl_a[2], ctl_a[0]});
      end
      tick();
      n_cmp++;
      if (exa !== 9'b0) begin n_bad++; $display("FAIL redir_bubble got=%b exp=0", exa); end
      redir = 1'b0; memrd = 1'b0; instr = mk(ADDI, 5'd1, 5'd2, 5'd0);
      #2;
      n_cmp++;
      if (ctl_a !== 3'b110) begin n_bad++; $display("FAIL redir_no_stall got=%b exp=110", ctl_a); end
      tick();
   endtask

   task automatic test_params();
      do_reset();
      memrd = 1'b1; rd = 5'd5; valid = 1'b1; redir = 1'b0;
      instr = mk(ROP, 5'd6, 5'd5, 5'd1);
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (ctl_b !== 3'b000) begin n_bad++; $display("FAIL b_stall%0d got=%b exp=000", i, ctl_b); end
         tick();
         n_cmp++;
         if (exb !== 9'b0) begin n_bad++; $display("FAIL b_stall_ex%0d got=%b exp=0", i, exb); end
         memrd = 1'b0;
      end
      #2;
      n_cmp++;
      if (ctl_b !== 3'b110) begin n_bad++; $display("FAIL b_run got=%b exp=110", ctl_b); end
      tick();
      n_cmp++;
      if (exb !== 9'b110000000) begin n_bad++; $display("FAIL b_issue got=%b exp=110000000", exb); end
      redir = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         n_cmp++;
         if ({ctl_b[2], ctl_b[0]} !== 2'b11) begin
            n_bad++; $display("FAIL b_flush%0d got=%b exp=11", i, {ctl_b[2], ctl_b[0]});
         end
         tick();
         n_cmp++;
         if (exb !== 9'b0) begin n_bad++; $display("FAIL b_flush_ex%0d got=%b exp=0", i, exb); end
         redir = 1'b0;
      end
      #2;
      n_cmp++;
      if (ctl_b !== 3'b110) begin n_bad++; $display("FAIL b_flush_done got=%b exp=110", ctl_b); end
      tick();
      memrd = 1'b1;
      #2;
      tick();
      memrd = 1'b0; rst = 1'b1;
      #2;
      n_cmp++;
      if (ctl_b !== 3'b001) begin n_bad++; $display("FAIL b_rst_mid_ctl got=%b exp=001", ctl_b); end
      tick();
      rst = 1'b0;
      #2;
      n_cmp++;
      if (ctl_b !== 3'b110) begin n_bad++; $display("FAIL b_rst_mid_run got=%b exp=110", ctl_b); end
      tick();
      n_cmp++;
      if (exb !== 9'b110000000) begin n_bad++; $display("FAIL b_rst_mid_ex got=%b exp=110000000", exb); end
   endtask

   task automatic test_decode_sweep();
      logic [6:0] op_t [0:6];
      logic [1:0] im_t [0:6];
      logic [8:0] ex_t [0:6];
      op_t = '{SW, BEQ, JAL, LW, ADDI, ROP, 7'b1111111};
      im_t = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      ex_t = '{9'b100100101, 9'b100010010, 9'b110001011, 9'b111000100,
               9'b110000100, 9'b110000000, 9'b000000000};
      do_reset();
      memrd = 1'b0; rd = 5'd0; redir = 1'b0; valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         instr = mk(op_t[i], 5'd9, 5'd10, 5'd11);
         #2;
         n_cmp++;
         if (ifa.immSel !== im_t[i] || ifa.illegal !== (i == 6)) begin
            n_bad++;
            $display("FAIL dec_imm%0d got=%b/%b exp=%b/%b", i, ifa.immSel, ifa.illegal, im_t[i], (i == 6));
         end
         tick();
         n_cmp++;
         if (exa !== ex_t[i]) begin n_bad++; $display("FAIL dec_ex%0d got=%b exp=%b", i, exa, ex_t[i]); end
      end
      valid = 1'b0;
      #2;
      n_cmp++;
      if (ifa.illegal !== 1'b0) begin n_bad++; $display("FAIL dec_illegal_invalid got=%b exp=0", ifa.illegal); end
      tick();
   endtask

   task automatic test_random();
      logic [2:0] ectl [2];
      logic       care [2];
      logic [8:0] enx  [2];
      logic [2:0] msk;
      logic [6:0] ops  [0:6];
      logic       known;
      logic       rs2u;
      logic [7:0] c;
      ops = '{LW, ADDI, SW, BEQ, JAL, ROP, 7'b0000000};
      do_reset();
      for (int k = 0; k < 2; k++) begin
         m_stall[k] = 0; m_flush[k] = 0; m_ex[k] = '0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         instr        = $urandom;
         instr[6:0]   = ops[$urandom_range(0, 6)];
         if (instr[6:0] == 7'b0000000) instr[6:0] = 7'($urandom);
         instr[19:15] = 5'($urandom_range(0, 7));
         instr[24:20] = 5'($urandom_range(0, 7));
         valid = ($urandom_range(0, 9) != 0);
         memrd = ($urandom_range(0, 2) != 0);
         rd    = 5'($urandom_range(0, 7));
         redir = ($urandom_range(0, 6) == 0);
         rst   = ($urandom_range(0, 39) == 0);
         #2;
         for (int k = 0; k < 2; k++) model_eval(k, ectl[k], care[k], enx[k]);
         ref_decode(instr[6:0], known, rs2u, c);
         n_cmp++;
         if (ifa.immSel !== c[1:0] || ifa.illegal !== (valid & ~known)) begin
            n_bad++;
            $display("FAIL rnd_decode cyc=%0d got=%b/%b exp=%b/%b", cyc, ifa.immSel, ifa.illegal, c[1:0], valid & ~known);
         end
         msk = care[0] ? 3'b111 : 3'b101;
         n_cmp++;
         if ((ctl_a & msk) !== (ectl[0] & msk)) begin
            n_bad++; $display("FAIL rnd_ctl_a cyc=%0d got=%b exp=%b mask=%b", cyc, ctl_a, ectl[0], msk);
         end
         msk = care[1] ? 3'b111 : 3'b101;
         n_cmp++;
         if ((ctl_b & msk) !== (ectl[1] & msk)) begin
            n_bad++; $display("FAIL rnd_ctl_b cyc=%0d got=%b exp=%b mask=%b", cyc, ctl_b, ectl[1], msk);
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            m_stall[k] = n_stall[k]; m_flush[k] = n_flush[k]; m_ex[k] = enx[k];
         end
         n_cmp++;
         if (exa !== m_ex[0]) begin n_bad++; $display("FAIL rnd_ex_a cyc=%0d got=%b exp=%b", cyc, exa, m_ex[0]); end
         n_cmp++;
         if (exb !== m_ex[1]) begin n_bad++; $display("FAIL rnd_ex_b cyc=%0d got=%b exp=%b", cyc, exb, m_ex[1]); end
      end
      rst = 1'b0; redir = 1'b0; memrd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_redirect_priority();
      test_params();
      test_decode_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
